// File: rtl/jk_sync_counter.sv
// Synchronous up/down counter built from JK toggle stages with load, terminal count and wrap pulse.
// Optional modulus limit enabled by defining JK_COUNTER_MODN_EN (adds the Mod port).
module jk_sync_counter #(
  parameter int WIDTH = 4
) (
  input  logic             CLK,
  input  logic             ClrN,
  input  logic             En,
  input  logic             Up,
  input  logic             Load,
  input  logic [WIDTH-1:0] D,
`ifdef JK_COUNTER_MODN_EN
  input  logic [WIDTH-1:0] Mod,
`endif
  output logic [WIDTH-1:0] Q,
  output logic             TC,
  output logic             Wrap
);

  logic [WIDTH-1:0] qR;
  logic             wrapR;
  logic [WIDTH-1:0] maxS;
  logic [WIDTH-1:0] toggleS;
  logic [WIDTH-1:0] jkQS;
  logic [WIDTH-1:0] qNextS;
  logic             tcS;

`ifdef JK_COUNTER_MODN_EN
  assign maxS = Mod;
`else
  assign maxS = {WIDTH{1'b1}};
`endif

  function automatic logic jkNext(input logic j, input logic k, input logic q);
    return (j & ~q) | (~k & q);
  endfunction

  // Ripple the toggle enable through the lower bits and apply JK behaviour with J=K=T
  always_comb begin
    logic carryS;
    toggleS = {WIDTH{1'b0}};
    jkQS    = {WIDTH{1'b0}};
    carryS  = En;
    for (int i = 0; i < WIDTH; i++) begin
      toggleS[i] = carryS;
      jkQS[i]    = jkNext(carryS, carryS, qR[i]);
      carryS     = carryS & (Up ? qR[i] : ~qR[i]);
    end
  end

  // Terminal count is forced low during reset and whenever a load is pending
  always_comb begin
    tcS = 1'b0;
    if (ClrN && En && !Load) begin
      if (Up) begin
        tcS = (qR >= maxS);
      end else begin
        tcS = (qR == {WIDTH{1'b0}});
      end
    end else begin
      tcS = 1'b0;
    end
  end

  // Next-state selection: load beats wrap, wrap beats ordinary count, otherwise hold
  always_comb begin
    qNextS = qR;
    if (Load) begin
      qNextS = D;
    end else if (tcS) begin
      qNextS = Up ? {WIDTH{1'b0}} : maxS;
    end else if (En) begin
      qNextS = jkQS;
    end else begin
      qNextS = qR;
    end
  end

  // Count and wrap-pulse registers; tcS is already zero on load or hold edges
  always_ff @(posedge CLK or negedge ClrN) begin
    if (!ClrN) begin
      qR    <= {WIDTH{1'b0}};
      wrapR <= 1'b0;
    end else begin
      qR    <= qNextS;
      wrapR <= tcS;
    end
  end

  assign Q    = qR;
  assign TC   = tcS;
  assign Wrap = wrapR;

endmodule

// File: tb/tb_jk_sync_counter.sv
// Directed self-checking bench for jk_sync_counter (WIDTH=4); exercises the modulus build
// as well when JK_COUNTER_MODN_EN is defined.
module tb_jk_sync_counter;

  logic       CLK;
  logic       ClrN;
  logic       En;
  logic       Up;
  logic       Load;
  logic [3:0] D;
  logic [3:0] Q;
  logic       TC;
  logic       Wrap;
`ifdef JK_COUNTER_MODN_EN
  logic [3:0] Mod;
`endif

  int errCount;
  int checkCount;

  jk_sync_counter #(.WIDTH(4)) dut (
    .CLK  (CLK),
    .ClrN (ClrN),
    .En   (En),
    .Up   (Up),
    .Load (Load),
    .D    (D),
`ifdef JK_COUNTER_MODN_EN
    .Mod  (Mod),
`endif
    .Q    (Q),
    .TC   (TC),
    .Wrap (Wrap)
  );

  initial CLK = 1'b0;
  always #5 CLK = ~CLK;

  task automatic check(input string tag, input int obs, input int expv);
    checkCount++;
    if (obs != expv) begin
      errCount++;
      $display("FAIL %s: got %0d, expected %0d", tag, obs, expv);
    end
  endtask

  task automatic tick();
    @(posedge CLK);
    #1;
  endtask

  task automatic expectState(input string tag, input int q, input int wrap, input int tc);
    check({tag, ".Q"}, int'(Q), q);
    check({tag, ".Wrap"}, int'(Wrap), wrap);
    check({tag, ".TC"}, int'(TC), tc);
  endtask

  task automatic loadValue(input logic [3:0] v);
    Load = 1'b1;
    En   = 1'b0;
    D    = v;
    tick();
    Load = 1'b0;
  endtask

  initial begin
    errCount   = 0;
    checkCount = 0;
    ClrN = 1'b0;
    En   = 1'b1;
    Up   = 1'b0;
    Load = 1'b0;
    D    = 4'd0;
`ifdef JK_COUNTER_MODN_EN
    Mod  = 4'd15;
`endif
    #2;
    expectState("reset", 0, 0, 0);
    #5;
    ClrN = 1'b1;
    En   = 1'b0;
    Up   = 1'b1;
    #1;

    // Up wrap: 14,15,0,1
    loadValue(4'd14);
    En = 1'b1; Up = 1'b1;
    #1;
    expectState("up14", 14, 0, 0);
    tick(); expectState("up15", 15, 0, 1);
    tick(); expectState("up0", 0, 1, 0);
    tick(); expectState("up1", 1, 0, 0);

    // Down wrap: 1,0,15,14
    loadValue(4'd1);
    En = 1'b1; Up = 1'b0;
    #1;
    expectState("dn1", 1, 0, 0);
    tick(); expectState("dn0", 0, 0, 1);
    tick(); expectState("dn15", 15, 1, 0);
    tick(); expectState("dn14", 14, 0, 0);

    // Load beats terminal count, then hold
    loadValue(4'd15);
    En = 1'b1; Up = 1'b1; Load = 1'b1; D = 4'd5;
    #1;
    check("prio.TC", int'(TC), 0);
    tick(); expectState("prio5", 5, 0, 0);
    Load = 1'b0; En = 1'b0;
    tick(); expectState("hold5", 5, 0, 0);

    // Wrap pulse clears on a hold edge
    loadValue(4'd15);
    En = 1'b1; Up = 1'b1;
    tick(); expectState("wrapUp", 0, 1, 0);
    En = 1'b0;
    tick(); expectState("wrapHold", 0, 0, 0);

    // Direction flip every edge: 8,7,8,7 with no wrap
    loadValue(4'd7);
    En = 1'b1;
    for (int i = 0; i < 4; i++) begin
      Up = (i % 2 == 0) ? 1'b1 : 1'b0;
      tick();
      expectState($sformatf("flip%0d", i), (i % 2 == 0) ? 8 : 7, 0, 0);
    end

    // Asynchronous reset between edges with Q=9
    loadValue(4'd9);
    check("pre9.Q", int'(Q), 9);
    En = 1'b1; Up = 1'b0;
    #2;
    ClrN = 1'b0;
    #1;
    expectState("arst9", 0, 0, 0);
    #2;
    ClrN = 1'b1;
    Up = 1'b1;
    tick(); expectState("postRst", 1, 0, 0);

    // Reset discards a pending wrap pulse; first edge after release counts normally
    loadValue(4'd15);
    En = 1'b1; Up = 1'b1;
    tick(); check("pend.Wrap", int'(Wrap), 1);
    #2;
    ClrN = 1'b0;
    #1;
    expectState("pendRst", 0, 0, 0);
    #2;
    ClrN = 1'b1;
    tick(); expectState("pendAfter", 1, 0, 0);

`ifdef JK_COUNTER_MODN_EN
    // Modulus 9: 0..9,0 with TC at 9
    Mod = 4'd9;
    loadValue(4'd0);
    En = 1'b1; Up = 1'b1;
    for (int i = 1; i <= 9; i++) begin
      tick();
      check($sformatf("mod%0d.Q", i), int'(Q), i);
    end
    check("mod9.TC", int'(TC), 1);
    tick(); expectState("mod0", 0, 1, 0);
    loadValue(4'd12);
    En = 1'b1; Up = 1'b1;
    #1;
    check("mod12.TC", int'(TC), 1);
    tick(); expectState("mod12wrap", 0, 1, 0);
    Up = 1'b0;
    #1;
    check("modDn.TC", int'(TC), 1);
    tick(); check("modDn.Q", int'(Q), 9);
    Mod = 4'd0;
    loadValue(4'd0);
    En = 1'b1; Up = 1'b1;
    #1;
    check("mod0hold.TC", int'(TC), 1);
    tick(); check("mod0hold.Q", int'(Q), 0);
`endif

    $display("Result: errors=%0d of %0d checks", errCount, checkCount);
    $finish;
  end

endmodule
